// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned DefDataWidth    = 32;
    localparam int unsigned DefAddressWidth = 12;
    localparam int unsigned PerfCntWidth    = 32;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        HALTED
    } fetch_state_t;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Fetch performance counters: completed transfers and decode-stall cycles.
// Only instantiated when FETCH_PERF_CNT_EN is defined.
module fetch_perf_cnt
    import fetch_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_transfer,
    input  logic                    i_stall,
    output logic [PerfCntWidth-1:0] o_fetch_count,
    output logic [PerfCntWidth-1:0] o_stall_count
);

    logic [PerfCntWidth-1:0] r_fetch_count;
    logic [PerfCntWidth-1:0] r_stall_count;

    // Free-running counters; wrap naturally at 2**PerfCntWidth.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fetch_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (i_transfer) r_fetch_count <= r_fetch_count + 1'b1;
            if (i_stall)    r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign o_fetch_count = r_fetch_count;
    assign o_stall_count = r_stall_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the instruction memory read
// port and hands fetched words to decode over a valid/ready handshake.
// Optional macro FETCH_PERF_CNT_EN adds fetch_count / stall_count outputs.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DefDataWidth,
    parameter int unsigned ADDRESS_WIDTH = DefAddressWidth,
    parameter int unsigned RESET_PC      = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     r_en_one,
    output logic [ADDRESS_WIDTH-1:0] r_adrs_one,
    input  logic [DATA_WIDTH-1:0]    r_data_one,
    output logic [DATA_WIDTH-1:0]    instr,
    output logic [ADDRESS_WIDTH-1:0] instr_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    input  logic                     redirect_en,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    input  logic                     halt,
`ifdef FETCH_PERF_CNT_EN
    output logic [PerfCntWidth-1:0]  fetch_count,
    output logic [PerfCntWidth-1:0]  stall_count,
`endif
    output logic                     halted
);

    localparam logic [ADDRESS_WIDTH-1:0] ResetPc = ADDRESS_WIDTH'(RESET_PC);

    fetch_state_t             r_state;
    logic [ADDRESS_WIDTH-1:0] r_pc;
    logic [ADDRESS_WIDTH-1:0] w_pc_inc;

    // Modulo-2**ADDRESS_WIDTH increment falls out of the fixed width.
    assign w_pc_inc = r_pc + 1'b1;

    // Fetch FSM; every output is a register updated on the transition into its state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_pc        <= ResetPc;
            r_en_one    <= 1'b0;
            r_adrs_one  <= ResetPc;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else if (redirect_en) begin
            // Redirect beats everything: a pending REQ word is simply not captured,
            // and a same-cycle HOLD transfer completes but pc takes the target.
            r_state     <= REQ;
            r_pc        <= redirect_pc;
            r_en_one    <= 1'b1;
            r_adrs_one  <= redirect_pc;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (halt) begin
                        r_state <= HALTED;
                        halted  <= 1'b1;
                    end else begin
                        r_state    <= REQ;
                        r_en_one   <= 1'b1;
                        r_adrs_one <= r_pc;
                    end
                end
                REQ: begin
                    // Memory latched the word on the falling edge; capture it now.
                    instr       <= r_data_one;
                    instr_pc    <= r_pc;
                    instr_valid <= 1'b1;
                    r_en_one    <= 1'b0;
                    r_state     <= HOLD;
                end
                HOLD: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        r_pc        <= w_pc_inc;
                        if (halt) begin
                            r_state <= HALTED;
                            halted  <= 1'b1;
                        end else begin
                            r_state    <= REQ;
                            r_en_one   <= 1'b1;
                            r_adrs_one <= w_pc_inc;
                        end
                    end
                end
                HALTED: begin
                    r_state <= HALTED;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic w_transfer;
    logic w_stall;

    assign w_transfer = instr_valid && instr_ready;
    assign w_stall    = (r_state == HOLD) && !instr_ready;

    fetch_perf_cnt u_perf_cnt (
        .i_clk         (clk),
        .i_rst_n       (reset),
        .i_transfer    (w_transfer),
        .i_stall       (w_stall),
        .o_fetch_count (fetch_count),
        .o_stall_count (stall_count)
    );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stimulus pushes expected
// (instr, pc) pairs; a negedge monitor pops one per handshake transfer.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        r_en_one;
    logic [11:0] r_adrs_one;
    logic [31:0] r_data_one = '0;
    logic [31:0] instr;
    logic [11:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic        redirect_en = 1'b0;
    logic [11:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    fetch_unit #(
        .DATA_WIDTH    (32),
        .ADDRESS_WIDTH (12),
        .RESET_PC      (0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .r_en_one    (r_en_one),
        .r_adrs_one  (r_adrs_one),
        .r_data_one  (r_data_one),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .halt        (halt),
`ifdef FETCH_PERF_CNT_EN
        .fetch_count (fetch_count),
        .stall_count (stall_count),
`endif
        .halted      (halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic [11:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_total = 0;
    int          n_pass  = 0;
    logic [31:0] mem [0:4095];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Memory read port samples on the falling edge.
    always @(negedge clk) begin
        if (r_en_one) r_data_one <= mem[r_adrs_one];
    end

    // Monitor: each handshake transfer must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (reset && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_transfer: got instr %0h pc %0h expected none",
                         instr, instr_pc);
            end else begin
                e = exp_q.pop_front();
                check("xfer_instr", 64'(instr), 64'(e.d));
                check("xfer_pc", 64'(instr_pc), 64'(e.pc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic [11:0] pc);
        exp_t e;
        e.d  = d;
        e.pc = pc;
        exp_q.push_back(e);
    endtask

    // Advance until HOLD presents the given pc; n = edges consumed.
    task automatic wait_hold(input logic [11:0] pc, output int n);
        n = 0;
        while (!(instr_valid && instr_pc == pc) && n < 20) begin
            tick();
            n++;
        end
        if (!(instr_valid && instr_pc == pc)) begin
            n_total++;
            $display("FAIL wait_hold_timeout: got pc %0h valid %0b expected pc %0h valid 1",
                     instr_pc, instr_valid, pc);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_r_en_one", 64'(r_en_one), 64'(0));
        check("rst_r_adrs_one", 64'(r_adrs_one), 64'(0));
        check("rst_instr", 64'(instr), 64'(0));
        check("rst_instr_pc", 64'(instr_pc), 64'(0));
        check("rst_instr_valid", 64'(instr_valid), 64'(0));
        check("rst_halted", 64'(halted), 64'(0));
`ifdef FETCH_PERF_CNT_EN
        check("rst_fetch_count", 64'(fetch_count), 64'(0));
        check("rst_stall_count", 64'(stall_count), 64'(0));
`endif
    endtask

    initial begin
        int n;
        for (int i = 0; i < 4096; i++) mem[i] = 32'hC000_0000 | i;
        mem[0]      = 32'h11;
        mem[1]      = 32'h22;
        mem[2]      = 32'h33;
        mem[3]      = 32'h44;
        mem[5]      = 32'h55;
        mem[12'h100] = 32'hAB;
        mem[12'hFFF] = 32'hFF;

        #12;
        check_reset_outputs();

        // Streaming at full rate: one instruction every 2 cycles.
        push(32'h11, 12'd0);
        push(32'h22, 12'd1);
        push(32'h33, 12'd2);
        push(32'h44, 12'd3);
        tick();
        reset = 1'b1;
        wait_hold(12'd0, n);
        check("latency_pc0", 64'(n), 64'(2));
        wait_hold(12'd1, n);
        check("spacing_pc1", 64'(n), 64'(2));
        wait_hold(12'd2, n);
        check("spacing_pc2", 64'(n), 64'(2));
        wait_hold(12'd3, n);

        // Halt during HOLD at pc 3: transfer completes, then fetch stops.
        halt = 1'b1;
        tick();
        check("halt_halted", 64'(halted), 64'(1));
        check("halt_valid", 64'(instr_valid), 64'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halt_r_en", 64'(r_en_one), 64'(0));
        end

        // Redirect out of HALTED, with halt still high: redirect wins.
        redirect_en = 1'b1;
        redirect_pc = 12'd5;
        push(32'h55, 12'd5);
        tick();
        redirect_en = 1'b0;
        halt        = 1'b0;
        check("redir_halted", 64'(halted), 64'(0));
        check("redir_r_adrs", 64'(r_adrs_one), 64'(5));
        wait_hold(12'd5, n);
        check("redir_latency", 64'(n), 64'(1));

        // Redirect while pc 6 is in flight: that word must never appear.
        tick();
        check("req_pc6_adrs", 64'(r_adrs_one), 64'(6));
        redirect_en = 1'b1;
        redirect_pc = 12'h100;
        push(32'hAB, 12'h100);
        tick();
        redirect_en = 1'b0;
        wait_hold(12'h100, n);

        // Wrap from 0xFFF to 0x000.
        tick();
        redirect_en = 1'b1;
        redirect_pc = 12'hFFF;
        push(32'hFF, 12'hFFF);
        push(32'h11, 12'h000);
        tick();
        redirect_en = 1'b0;
        wait_hold(12'hFFF, n);
        wait_hold(12'h000, n);

        // Backpressure at pc 1 for 5 cycles.
        push(32'h22, 12'd1);
        wait_hold(12'd1, n);
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_instr", 64'(instr), 64'(32'h22));
            check("bp_pc", 64'(instr_pc), 64'(1));
            check("bp_r_en", 64'(r_en_one), 64'(0));
        end
`ifdef FETCH_PERF_CNT_EN
        check("stall_count", 64'(stall_count), 64'(5));
        check("fetch_count", 64'(fetch_count), 64'(8));
`endif
        push(32'h33, 12'd2);
        instr_ready = 1'b1;
        wait_hold(12'd2, n);
        check("bp_resume", 64'(n), 64'(2));

        // Reset asserted while pc 3 is being requested.
        tick();
        check("pre_rst_r_en", 64'(r_en_one), 64'(1));
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Fresh start at RESET_PC, then redirect coinciding with a HOLD transfer.
        push(32'h11, 12'd0);
        wait_hold(12'd0, n);
        check("post_rst_latency", 64'(n), 64'(2));
        redirect_en = 1'b1;
        redirect_pc = 12'h100;
        push(32'hAB, 12'h100);
        tick();
        redirect_en = 1'b0;
        check("xfer_redir_adrs", 64'(r_adrs_one), 64'(12'h100));
        wait_hold(12'h100, n);
        halt = 1'b1;
        tick();
        tick();
        check("final_halted", 64'(halted), 64'(1));
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
`ifdef FETCH_PERF_CNT_EN
        check("final_fetch_count", 64'(fetch_count), 64'(2));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
